// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared framing constants, FSM states and error codes for the UART frame link
package uart_frame_pkg;
  localparam logic [7:0] SOM = 8'h73;
  localparam logic [7:0] EOM = 8'h65;
  typedef enum logic [2:0] {HUNT, B3, B2, B1, B0, TAIL} state_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_EOM     = 2'd1;
  localparam logic [1:0] ERR_UART    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
endpackage

// File: rtl/uart_frame_timeout.sv
// uart_frame_timeout: idle counter that pulses o_expire after TIMEOUT_CYCLES enabled cycles without a clear
module uart_frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int unsigned W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [W-1:0] r_cnt;
  // expiry is seen in the cycle before the edge that reports it; a clear in that cycle wins
  assign o_expire = (TIMEOUT_CYCLES != 0) && i_en && !i_clr && r_cnt == LIMIT;
  // count enabled idle cycles; clear (reload zero) on byte, disable or expiry
  always_ff @(posedge clk)
    if (reset || i_clr || !i_en || o_expire) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: hunts for SOM, assembles a 4-byte MSB-first word, validates EOM and reports bad frames
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_from_uart_data,
  input  logic        i_from_uart_valid,
  input  logic        i_from_uart_error,
  output logic        o_from_uart_ready,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  output logic        o_frame_error,
  output logic [1:0]  o_err_code,
  output logic [15:0] o_good_frames,
  output logic [15:0] o_bad_frames
);
  state_t      r_state;
  logic        r_ready;
  logic [31:0] r_shadow;
  logic [31:0] r_word;
  logic        r_word_valid;
  logic        r_frame_error;
  logic [1:0]  r_err_code;
  logic [15:0] r_good;
  logic [15:0] r_bad;
  logic        w_accept;
  logic        w_expire;
  assign w_accept          = i_from_uart_valid && r_ready;
  assign o_from_uart_ready = r_ready;
  assign o_word            = r_word;
  assign o_word_valid      = r_word_valid;
  assign o_frame_error     = r_frame_error;
  assign o_err_code        = r_err_code;
  assign o_good_frames     = r_good;
  assign o_bad_frames      = r_bad;
  uart_frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_accept),
    .i_en     (r_state != HUNT),
    .o_expire (w_expire)
  );
  // frame FSM: payload shifts in MSB-first, outputs and saturating counters are registered
  always_ff @(posedge clk)
    if (reset) begin
      r_state       <= HUNT;
      r_ready       <= 1'b0;
      r_shadow      <= '0;
      r_word        <= '0;
      r_word_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_good        <= '0;
      r_bad         <= '0;
    end else begin
      r_ready       <= 1'b1;
      r_word_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      if (w_accept && r_state != HUNT && i_from_uart_error) begin
        r_frame_error <= 1'b1;
        r_err_code    <= ERR_UART;
        r_bad         <= r_bad + {15'd0, ~&r_bad};
        r_state       <= HUNT;
      end else if (w_accept) begin
        case (r_state)
          HUNT: r_state <= (!i_from_uart_error && i_from_uart_data == SOM) ? B3 : HUNT;
          TAIL: begin
            if (i_from_uart_data == EOM) begin
              r_word       <= r_shadow;
              r_word_valid <= 1'b1;
              r_good       <= r_good + {15'd0, ~&r_good};
              r_state      <= HUNT;
            end else begin
              r_frame_error <= 1'b1;
              r_err_code    <= ERR_EOM;
              r_bad         <= r_bad + {15'd0, ~&r_bad};
              r_state       <= i_from_uart_data == SOM ? B3 : HUNT;
            end
          end
          default: begin
            r_shadow <= {r_shadow[23:0], i_from_uart_data};
            r_state  <= r_state == B0 ? TAIL : state_t'(r_state + 3'd1);
          end
        endcase
      end else if (w_expire) begin
        r_frame_error <= 1'b1;
        r_err_code    <= ERR_TIMEOUT;
        r_bad         <= r_bad + {15'd0, ~&r_bad};
        r_state       <= HUNT;
      end
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed and random byte streams checked cycle by cycle against a queue-based frame model
module tb_uart_frame_rx;
  localparam int unsigned TO = 16;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_err = 1'b0;
  logic        ready;
  logic [31:0] word;
  logic        word_valid;
  logic        frame_error;
  logic [1:0]  err_code;
  logic [15:0] good_frames;
  logic [15:0] bad_frames;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_word;
  logic        m_wv, m_fe, m_ready, m_in;
  logic [1:0]  m_code;
  logic [15:0] m_good, m_bad;
  int          m_idle;
  logic [7:0]  m_q[$];
  logic [7:0]  seq[$];

  uart_frame_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_from_uart_data  (i_data),
    .i_from_uart_valid (i_valid),
    .i_from_uart_error (i_err),
    .o_from_uart_ready (ready),
    .o_word            (word),
    .o_word_valid      (word_valid),
    .o_frame_error     (frame_error),
    .o_err_code        (err_code),
    .o_good_frames     (good_frames),
    .o_bad_frames      (bad_frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    m_word = '0; m_wv = 0; m_fe = 0; m_code = 0; m_good = 0; m_bad = 0;
    m_ready = 0; m_in = 0; m_idle = 0; m_q.delete();
  endtask

  task automatic bad_frame(input logic [1:0] code);
    m_fe = 1; m_code = code; m_bad = sat_inc(m_bad);
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic e);
    m_wv = 0; m_fe = 0;
    if (v && m_ready) begin
      m_idle = 0;
      if (!m_in) begin
        if (!e && d == 8'h73) begin m_in = 1; m_q.delete(); end
      end else if (e) begin
        bad_frame(2'd2); m_in = 0;
      end else if (m_q.size() < 4) begin
        m_q.push_back(d);
      end else if (d == 8'h65) begin
        m_word = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_wv = 1; m_good = sat_inc(m_good); m_in = 0;
      end else begin
        bad_frame(2'd1); m_in = (d == 8'h73); m_q.delete();
      end
    end else if (m_in) begin
      m_idle++;
      if (m_idle == TO) begin bad_frame(2'd3); m_in = 0; end
    end
    m_ready = 1;
  endtask

  task automatic compare();
    chk("ready", ready, m_ready);
    chk("word", word, m_word);
    chk("word_valid", word_valid, m_wv);
    chk("frame_error", frame_error, m_fe);
    chk("err_code", err_code, m_code);
    chk("good_frames", good_frames, m_good);
    chk("bad_frames", bad_frames, m_bad);
    chk("wv_fe_exclusive", word_valid & frame_error, 0);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic e);
    i_valid = v; i_data = d; i_err = e;
    @(posedge clk); #1;
    model_step(v, d, e);
    compare();
  endtask

  task automatic do_reset();
    reset = 1; i_valid = 0; i_err = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare();
    reset = 0;
  endtask

  task automatic send_seq();
    foreach (seq[k]) step(1'b1, seq[k], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #1;
    do_reset();
    idle(1);
    seq = '{8'h73, 8'h12, 8'h34, 8'h56, 8'h78, 8'h65};
    send_seq();
    chk("tp_good_word", word, 32'h12345678);
    chk("tp_good_pulse", word_valid, 1);
    chk("tp_good_cnt", good_frames, 1);
    chk("tp_good_bad", bad_frames, 0);
    idle(1);
    chk("tp_pulse_one_cycle", word_valid, 0);
    do_reset();
    idle(1);
    seq = '{8'h00, 8'hFF, 8'h73, 8'h73, 8'h65, 8'h73, 8'h65, 8'h65};
    send_seq();
    chk("tp_marker_word", word, 32'h73657365);
    chk("tp_marker_good", good_frames, 1);
    chk("tp_marker_bad", bad_frames, 0);
    do_reset();
    idle(1);
    seq = '{8'h73, 8'h01, 8'h02, 8'h03, 8'h04, 8'h73};
    send_seq();
    chk("tp_tail_fe", frame_error, 1);
    chk("tp_tail_code", err_code, 1);
    seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h65};
    send_seq();
    chk("tp_resync_word", word, 32'hAABBCCDD);
    chk("tp_resync_good", good_frames, 1);
    chk("tp_resync_bad", bad_frames, 1);
    do_reset();
    idle(1);
    step(1, 8'h73, 0);
    step(1, 8'h11, 0);
    step(1, 8'h22, 1);
    chk("tp_uart_fe", frame_error, 1);
    chk("tp_uart_code", err_code, 2);
    seq = '{8'h33, 8'h44, 8'h55, 8'h65};
    send_seq();
    chk("tp_uart_noword", good_frames, 0);
    step(1, 8'h73, 1);
    step(1, 8'h01, 0);
    chk("tp_hunt_err_drop", bad_frames, 1);
    do_reset();
    idle(1);
    seq = '{8'h73, 8'h01, 8'h02};
    send_seq();
    idle(TO - 1);
    chk("tp_to_early", frame_error, 0);
    idle(1);
    chk("tp_to_fire", frame_error, 1);
    chk("tp_to_code", err_code, 3);
    idle(TO + 2);
    chk("tp_to_once", bad_frames, 1);
    seq = '{8'h73, 8'h01, 8'h02};
    send_seq();
    idle(TO - 1);
    step(1, 8'h03, 0);
    chk("tp_to_suppressed", frame_error, 0);
    idle(TO);
    chk("tp_to_refire", frame_error, 1);
    chk("tp_to_bad2", bad_frames, 2);
    idle(1);
    seq = '{8'h73, 8'h01};
    send_seq();
    do_reset();
    chk("tp_rst_ready", ready, 0);
    chk("tp_rst_bad", bad_frames, 0);
    step(1, 8'h73, 0);
    seq = '{8'h73, 8'h01, 8'h02, 8'h03, 8'h04, 8'h65,
            8'h73, 8'h05, 8'h06, 8'h07, 8'h08, 8'h65,
            8'h73, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h65};
    send_seq();
    chk("tp_b2b_word", word, 32'h090A0B0C);
    chk("tp_b2b_good", good_frames, 3);
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        do_reset();
      end else if (r < 8) begin
        idle(int'($urandom_range(10, 20)));
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2: b = 8'h73;
          3, 4:    b = 8'h65;
          default: b = 8'($urandom);
        endcase
        step(r < 160, b, $urandom_range(0, 29) == 0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
